// File: rtl/word_stream_unpacker.sv
// Word-to-byte stream unpacker: takes a per-message byte count and WORD_BYTES-wide words,
// emits one byte per cycle with out_last on the final byte. Optional macro: WORD_UNPACK_MSB_FIRST_EN.
module word_stream_unpacker #(
    parameter int WORD_BYTES = 4,
    parameter int MAX_SIZE   = 4096,
    localparam int SW        = $clog2(MAX_SIZE + 1),
    localparam int IW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SW-1:0]           cmd_size,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_last,
    output logic                    done,
    output logic                    busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

    logic [1:0]              state;
    logic [SW-1:0]           bytes_left;
    logic [IW-1:0]           byte_idx;
    logic [8*WORD_BYTES-1:0] word_reg;
    logic                    done_r;
    logic [7:0]              sel_byte;
    logic                    fire;
    logic                    word_end;
    logic                    more_after;

    assign fire       = out_valid && out_ready;
    assign word_end   = (byte_idx == LAST_IDX);
    assign more_after = (bytes_left > SW'(1));

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign out_last  = out_valid && (bytes_left == SW'(1));
    assign done      = done_r;
    // Refill is offered in the same cycle the last byte of a word is accepted, so no bubble.
    assign in_ready  = (state == LOAD) || (fire && word_end && more_after);

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (byte_idx == IW'(i)) begin
`ifdef WORD_UNPACK_MSB_FIRST_EN
                sel_byte = word_reg[8*(WORD_BYTES-1-i) +: 8];
`else
                sel_byte = word_reg[8*i +: 8];
`endif
            end
        end
        out_data = out_valid ? sel_byte : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bytes_left <= '0;
            byte_idx   <= '0;
            word_reg   <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_size == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            bytes_left <= cmd_size;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        word_reg <= in_data;
                        byte_idx <= '0;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (fire) begin
                        bytes_left <= bytes_left - SW'(1);
                        if (!more_after) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end else if (word_end) begin
                            byte_idx <= '0;
                            if (in_valid) begin
                                word_reg <= in_data;
                            end else begin
                                state <= LOAD;
                            end
                        end else begin
                            byte_idx <= byte_idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
